init_assign_loader: RTL and testbench

- Downstream consumer of the initialisation address sweep (3-bit address stepping 0..7 while the sweep controller is in its initial state).
- For each swept address, writes a pseudo-random W-bit initial variable assignment from an internal LFSR into an 8-entry table.
- Raises completion/valid flags when all 8 entries are written.
- Exposes a registered read port for the solver datapath.

---
 rtl/init_assign_loader.sv | 122 ++++++++++++
 tb/tb_init_assign_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/init_assign_loader.sv
// Initial assignment loader: fills an 8-entry table from an LFSR during the upstream address sweep.
// Optional checksum register built only when INIT_CHECKSUM_EN is defined.
module init_assign_loader #(
  parameter int         W         = 8,
  parameter logic [W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [W-1:0] LFSR_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_active,
  input  logic [2:0]   address,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
  input  logic [2:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic         busy,
  output logic         init_done,
  output logic         table_valid,
  output logic         seq_err,
  output logic [W-1:0] checksum
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t       state, state_d;
  logic [W-1:0] mem [8];
  logic [W-1:0] lfsr;
  logic [W-1:0] lfsr_next;
  logic [W-1:0] seed_fix;
  logic [2:0]   expected;
  logic [7:0]   valid;
  logic         wr, start, err, last;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS)
                             : (lfsr >> 1);
  assign seed_fix  = (seed == '0) ? {{(W-1){1'b0}}, 1'b1} : seed;
  assign busy        = (state == FILL);
  assign table_valid = &valid;

  // Next-state and write/error decode for the sweep follower
  always_comb begin
    state_d = state;
    wr      = 1'b0;
    start   = 1'b0;
    err     = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (init_active) begin
          if (address == 3'd0) begin
            wr      = 1'b1;
            start   = 1'b1;
            state_d = FILL;
          end else begin
            err = 1'b1;
          end
        end
      end
      FILL: begin
        if (init_active && (address == expected)) begin
          wr = 1'b1;
          if (address == 3'd7) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Table, LFSR, sweep tracking and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      lfsr      <= LFSR_INIT;
      expected  <= 3'd0;
      valid     <= 8'h00;
      rd_data   <= '0;
      init_done <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      rd_data   <= mem[rd_addr];
      init_done <= last;
      if (err) seq_err <= 1'b1;
      if (wr) begin
        mem[address] <= lfsr;
        lfsr         <= lfsr_next;
        expected     <= address + 3'd1;
      end else if ((state == IDLE) && seed_load) begin
        lfsr <= seed_fix;
      end
      if (start)   valid <= 8'h01;
      else if (wr) valid[address] <= 1'b1;
    end
  end

`ifdef INIT_CHECKSUM_EN
  logic [W-1:0] cs;

  // Running XOR of every value written in the current sweep
  always_ff @(posedge clk) begin
    if (rst)        cs <= '0;
    else if (start) cs <= lfsr;
    else if (wr)    cs <= cs ^ lfsr;
  end

  assign checksum = cs;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_init_assign_loader.sv
// Scoreboard bench for init_assign_loader.
// Read data expectations queue up at drive time and retire one cycle later.
module tb_init_assign_loader;

  logic       clk = 1'b0;
  logic       rst, init_active, seed_load;
  logic [2:0] address, rd_addr;
  logic [7:0] seed, rd_data, checksum;
  logic       busy, init_done, table_valid, seq_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rd_q [$];
  logic [7:0] m_mem [8];
  logic [7:0] m_lfsr, m_cs;
  logic [7:0] m_valid;
  logic [2:0] m_exp;
  logic       m_fill, m_err, m_done;
  logic [7:0] golden [8];

  always #5 clk = ~clk;

  init_assign_loader dut (
    .clk(clk), .rst(rst), .init_active(init_active),
    .address(address), .seed_load(seed_load), .seed(seed),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .init_done(init_done), .table_valid(table_valid),
    .seq_err(seq_err), .checksum(checksum)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_lfsr  = 8'h01;
    m_cs    = 8'h00;
    m_valid = 8'h00;
    m_exp   = 3'd0;
    m_fill  = 1'b0;
    m_err   = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic first);
    m_mem[a] = m_lfsr;
    if (first) begin
      m_cs    = m_lfsr;
      m_valid = 8'h01;
    end else begin
      m_cs       = m_cs ^ m_lfsr;
      m_valid[a] = 1'b1;
    end
    m_lfsr = step(m_lfsr);
    m_exp  = a + 3'd1;
  endtask

  task automatic cyc(input logic r, input logic ia,
                     input logic [2:0] a, input logic sl,
                     input logic [7:0] sd, input logic [2:0] ra);
    logic [7:0] e_cs;
    logic [7:0] e_rd;
    @(negedge clk);
    rst = r; init_active = ia; address = a;
    seed_load = sl; seed = sd; rd_addr = ra;
    if (r) begin
      model_reset();
      rd_q.push_back(8'h00);
    end else begin
      rd_q.push_back(m_mem[ra]);
      m_done = 1'b0;
      if (!m_fill) begin
        if (ia) begin
          if (a == 3'd0) begin
            model_write(a, 1'b1);
            m_fill = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end else if (sl) begin
          m_lfsr = (sd == 8'h00) ? 8'h01 : sd;
        end
      end else begin
        if (ia && (a == m_exp)) begin
          model_write(a, 1'b0);
          if (a == 3'd7) begin
            m_fill = 1'b0;
            m_done = 1'b1;
          end
        end else begin
          m_err  = 1'b1;
          m_fill = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    e_rd = rd_q.pop_front();
`ifdef INIT_CHECKSUM_EN
    e_cs = m_cs;
`else
    e_cs = 8'h00;
`endif
    check("rd_data", rd_data, e_rd);
    check("busy", busy, m_fill);
    check("init_done", init_done, m_done);
    check("table_valid", table_valid, m_valid == 8'hFF);
    check("seq_err", seq_err, m_err);
    check("checksum", checksum, e_cs);
  endtask

  task automatic idle(input logic [2:0] ra);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, ra);
  endtask

  task automatic read_golden(input string tag);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      check(tag, rd_data, golden[i]);
    end
  endtask

  initial begin
    golden = '{8'h01, 8'hB8, 8'h5C, 8'h2E,
               8'h17, 8'hB3, 8'hE1, 8'hC8};
    rst = 1'b1; init_active = 1'b0; address = 3'd0;
    seed_load = 1'b0; seed = 8'h00; rd_addr = 3'd0;
    model_reset();

    cyc(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 3'(i), 1'b0, 8'h00, 3'(i));
    check("done_pulse", init_done, 1'b1);
    check("valid_set", table_valid, 1'b1);
    idle(3'd0);
    check("done_once", init_done, 1'b0);
`ifdef INIT_CHECKSUM_EN
    check("cs_const", checksum, 8'h46);
`else
    check("cs_const", checksum, 8'h00);
`endif
    read_golden("tbl1");

    cyc(1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 3'(i), 1'b1, 8'h5A, 3'd0);
    read_golden("tbl2");

    cyc(1'b0, 1'b0, 3'd0, 1'b1, 8'h5A, 3'd0);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 3'(i), 1'b0, 8'h00, 3'd0);
    idle(3'd5);
    check("drop_err", seq_err, 1'b1);
    check("drop_valid", table_valid, 1'b0);
    check("drop_keep5", rd_data, 8'hB3);
    idle(3'd0);
    check("drop_new0", rd_data, 8'h5A);
    for (int i = 0; i < 8; i++) idle(3'(i));

    cyc(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0);
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0);
    cyc(1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 3'd0);
    cyc(1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 3'd3);
    check("skip_err", seq_err, 1'b1);
    check("skip_idle", busy, 1'b0);
    idle(3'd3);
    check("skip_mem3", rd_data, 8'h00);

    cyc(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd5);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 3'(i), 1'b0, 8'h00, 3'd5);
      if (i == 5) check("rbw_old", rd_data, 8'h00);
      if (i == 6) check("rbw_new", rd_data, 8'hB3);
    end
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 3'(i), 1'b0, 8'h00, 3'd0);
    check("b2b_busy", busy, 1'b1);
    cyc(1'b1, 1'b1, 3'd4, 1'b0, 8'h00, 3'd0);
    idle(3'd0);
    check("mid_rst_done", init_done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cs", checksum, 8'h00);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      check("mid_rst_tbl", rd_data, 8'h00);
    end

    check("queue_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
